// File: rtl/dc_pkg.sv
// ============================================================================
// Module : dc_pkg
// Brief  : Shared widths, bit-slice constants and types for the DRAM-cache
//          tag-check stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dc_pkg;

    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 512;
    localparam int TAG_S     = 64;
    localparam int TAG_W     = 16;
    localparam int INDEX_W   = 10;
    localparam int ID_W      = 16;
    localparam int REQ_DEPTH = 4;

    localparam int TAG_MSB   = 63;
    localparam int TAG_LSB   = 48;
    localparam int INDEX_MSB = 47;
    localparam int INDEX_LSB = 38;

    localparam int META_VALID_BIT = 575;
    localparam int META_DIRTY_BIT = 574;
    localparam int META_TAG_MSB   = 573;
    localparam int META_TAG_LSB   = 558;
    localparam int META_RSVD_W    = TAG_S - 2 - TAG_W;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
    } req_t;

    // Field order mirrors the bit layout of the metadata word, MSB first.
    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [TAG_W-1:0]       tag;
        logic [META_RSVD_W-1:0] rsvd;
    } meta_t;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[TAG_MSB:TAG_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dc_req_fifo.sv
// ============================================================================
// Module : dc_req_fifo
// Brief  : Synchronous FIFO holding issued requests; accepts a push while
//          full when a pop happens in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dc_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_o   = (cnt_q == '0);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign rdata_o   = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (w_do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dc_tag_compare.sv
// ============================================================================
// Module : dc_tag_compare
// Brief  : Pairs in-order memory responses with queued requests, compares
//          tags and routes the line to the hit or miss channel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dc_tag_compare
    import dc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_W-1:0]         req_id_i,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    m_rid_i,
    input  logic [TAG_S+DATA_W-1:0] m_rdata_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    output logic [ID_W-1:0]         hit_id_o,
    output logic [DATA_W-1:0]       hit_data_o,
    output logic                    hit_valid_o,
    input  logic                    hit_ready_i,
    output logic [ID_W-1:0]         miss_id_o,
    output logic [ADDR_W-1:0]       miss_addr_o,
    output logic [TAG_W-1:0]        miss_vtag_o,
    output logic                    miss_vdirty_o,
    output logic [DATA_W-1:0]       miss_vdata_o,
    output logic                    miss_valid_o,
    input  logic                    miss_ready_i,
    output logic [31:0]             hit_cnt_o,
    output logic [31:0]             miss_cnt_o
);

    logic [$bits(req_t)-1:0] w_head_raw;
    req_t                    w_head;
    meta_t                   w_meta;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_accept;
    logic                    w_hit;
    logic                    w_out_fire;
    logic                    w_unused;

    out_state_e          state_q;
    logic                hit_valid_q;
    logic                miss_valid_q;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [TAG_W-1:0]    vtag_q;
    logic                vdirty_q;
    logic [DATA_W-1:0]   data_q;
    logic [31:0]         hit_cnt_q;
    logic [31:0]         hit_cnt_d;
    logic [31:0]         miss_cnt_q;
    logic [31:0]         miss_cnt_d;

    dc_req_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH ($bits(req_t))
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_valid_i),
        .wdata_i ({req_id_i, req_addr_i}),
        .pop_i   (w_accept),
        .rdata_o (w_head_raw),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign w_head = req_t'(w_head_raw);
    assign w_meta = meta_t'(m_rdata_i[TAG_S+DATA_W-1:DATA_W]);

    // A held result may be replaced in the same cycle it leaves, giving one result per cycle.
    assign w_out_fire = (hit_valid_q && hit_ready_i) || (miss_valid_q && miss_ready_i);
    assign m_rready_o = !w_fifo_empty && ((state_q == OUT_EMPTY) || w_out_fire);
    assign w_accept   = m_rvalid_i && m_rready_o;
    assign w_hit      = w_meta.valid && (w_meta.tag == addr_tag(w_head.addr));

    assign req_ready_o = !w_fifo_full;

    assign w_unused = ^{m_rid_i, w_meta.rsvd};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= OUT_EMPTY;
            hit_valid_q  <= 1'b0;
            miss_valid_q <= 1'b0;
            id_q         <= '0;
            addr_q       <= '0;
            vtag_q       <= '0;
            vdirty_q     <= 1'b0;
            data_q       <= '0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (w_accept) begin
                        state_q <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (!w_accept && w_out_fire) begin
                        state_q      <= OUT_EMPTY;
                        hit_valid_q  <= 1'b0;
                        miss_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= OUT_EMPTY;
                    hit_valid_q  <= 1'b0;
                    miss_valid_q <= 1'b0;
                end
            endcase
            if (w_accept) begin
                hit_valid_q  <= w_hit;
                miss_valid_q <= !w_hit;
                id_q         <= w_head.id;
                addr_q       <= w_head.addr;
                vtag_q       <= w_meta.tag;
                vdirty_q     <= w_meta.valid && w_meta.dirty;
                data_q       <= m_rdata_i[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_valid_q && hit_ready_i && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (miss_valid_q && miss_ready_i && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_id_o      = id_q;
    assign hit_data_o    = data_q;
    assign hit_valid_o   = hit_valid_q;
    assign miss_id_o     = id_q;
    assign miss_addr_o   = addr_q;
    assign miss_vtag_o   = vtag_q;
    assign miss_vdirty_o = vdirty_q;
    assign miss_vdata_o  = data_q;
    assign miss_valid_o  = miss_valid_q;
    assign hit_cnt_o     = hit_cnt_q;
    assign miss_cnt_o    = miss_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dc_tag_compare.sv
// ============================================================================
// Module : tb_dc_tag_compare
// Brief  : Self-checking bench: directed vector table, hand-written corner
//          sequences and a randomized run against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dc_tag_compare;
    import dc_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [ID_W-1:0]         req_id_i;
    logic [ADDR_W-1:0]       req_addr_i;
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    m_rid_i;
    logic [TAG_S+DATA_W-1:0] m_rdata_i;
    logic                    m_rvalid_i;
    logic                    m_rready_o;
    logic [ID_W-1:0]         hit_id_o;
    logic [DATA_W-1:0]       hit_data_o;
    logic                    hit_valid_o;
    logic                    hit_ready_i;
    logic [ID_W-1:0]         miss_id_o;
    logic [ADDR_W-1:0]       miss_addr_o;
    logic [TAG_W-1:0]        miss_vtag_o;
    logic                    miss_vdirty_o;
    logic [DATA_W-1:0]       miss_vdata_o;
    logic                    miss_valid_o;
    logic                    miss_ready_i;
    logic [31:0]             hit_cnt_o;
    logic [31:0]             miss_cnt_o;

    dc_tag_compare dut (
        .clk           (clk),
        .rst           (rst),
        .req_id_i      (req_id_i),
        .req_addr_i    (req_addr_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .m_rid_i       (m_rid_i),
        .m_rdata_i     (m_rdata_i),
        .m_rvalid_i    (m_rvalid_i),
        .m_rready_o    (m_rready_o),
        .hit_id_o      (hit_id_o),
        .hit_data_o    (hit_data_o),
        .hit_valid_o   (hit_valid_o),
        .hit_ready_i   (hit_ready_i),
        .miss_id_o     (miss_id_o),
        .miss_addr_o   (miss_addr_o),
        .miss_vtag_o   (miss_vtag_o),
        .miss_vdirty_o (miss_vdirty_o),
        .miss_vdata_o  (miss_vdata_o),
        .miss_valid_o  (miss_valid_o),
        .miss_ready_i  (miss_ready_i),
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int eh    = 0;
    int em    = 0;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic              mv;
        logic              md;
        logic [TAG_W-1:0]  mtag;
        logic [DATA_W-1:0] line;
        logic              exp_hit;
        logic              exp_vdirty;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TAG_S+DATA_W-1:0] mk_rdata(input logic v, input logic d,
            input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] line);
        logic [META_RSVD_W-1:0] rsvd;
        rsvd = META_RSVD_W'({$urandom, $urandom});
        return {v, d, t, rsvd, line};
    endfunction

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] l;
        for (int i = 0; i < DATA_W / 32; i++) begin
            l[i*32 +: 32] = $urandom;
        end
        return l;
    endfunction

    task automatic push_req(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr);
        req_valid_i = 1'b1;
        req_id_i    = id;
        req_addr_i  = addr;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, " hit_cnt"}, DATA_W'(hit_cnt_o), DATA_W'(eh));
        chk({tag, " miss_cnt"}, DATA_W'(miss_cnt_o), DATA_W'(em));
    endtask

    // Random-phase reference state: pending requests plus one held result.
    req_t              mq [$];
    logic              mo_v;
    logic              mo_hit;
    req_t              mo_req;
    logic [TAG_W-1:0]  mo_tag;
    logic              mo_vd;
    logic [DATA_W-1:0] mo_line;
    logic [TAG_W-1:0]  tag_pool [4];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic              r_v, r_d, fire, exp_rready, accept;
        logic [TAG_W-1:0]  r_tag;
        logic [DATA_W-1:0] r_line;
        logic [DATA_W-1:0] la, lb;
        req_t              head;
        int                sz;

        vecs[0] = '{16'h0001, 64'habcd1234abcd1234, 1'b1, 1'b0, 16'habcd, 512'haaaa_bbbb, 1'b1, 1'b0};
        vecs[1] = '{16'h0002, 64'habcd1234abcd1234, 1'b1, 1'b1, 16'h1111, 512'hdead_beef,  1'b0, 1'b1};
        vecs[2] = '{16'h0003, 64'habcd1234abcd1234, 1'b0, 1'b0, 16'habcd, 512'h1234_5678,  1'b0, 1'b0};
        vecs[3] = '{16'h0004, 64'h1111000000000000, 1'b1, 1'b1, 16'h1111, 512'hcafe,       1'b1, 1'b0};
        vecs[4] = '{16'h0005, 64'hffffffffffffffff, 1'b1, 1'b0, 16'hfffe, {16{32'h5a5a5a5a}}, 1'b0, 1'b0};
        vecs[5] = '{16'h0006, 64'h0000000000000000, 1'b0, 1'b1, 16'h0000, 512'h77,         1'b0, 1'b0};
        vecs[6] = '{16'hffff, 64'h8000000000000001, 1'b1, 1'b1, 16'h8000, {16{32'hffffffff}}, 1'b1, 1'b0};
        vecs[7] = '{16'h0007, 64'h0001234500000000, 1'b1, 1'b1, 16'h0000, 512'h9,          1'b0, 1'b1};
        tag_pool = '{16'h0000, 16'habcd, 16'h1234, 16'hffff};

        rst          = 1'b1;
        req_id_i     = '0;
        req_addr_i   = '0;
        req_valid_i  = 1'b0;
        m_rid_i      = 1'b0;
        m_rdata_i    = '0;
        m_rvalid_i   = 1'b0;
        hit_ready_i  = 1'b1;
        miss_ready_i = 1'b1;
        tick();
        tick();

        chk("rst req_ready", DATA_W'(req_ready_o), DATA_W'(1'b1));
        chk("rst m_rready", DATA_W'(m_rready_o), DATA_W'(1'b0));
        chk("rst hit_valid", DATA_W'(hit_valid_o), DATA_W'(1'b0));
        chk("rst miss_valid", DATA_W'(miss_valid_o), DATA_W'(1'b0));
        check_counts("rst");
        rst = 1'b0;

        // Response offered with nothing queued must be held off.
        m_rvalid_i = 1'b1;
        m_rdata_i  = mk_rdata(1'b1, 1'b0, 16'h0, 512'h1);
        #1;
        chk("empty m_rready", DATA_W'(m_rready_o), DATA_W'(1'b0));
        tick();
        m_rvalid_i = 1'b0;
        chk("empty no result", DATA_W'(hit_valid_o | miss_valid_o), DATA_W'(1'b0));

        for (int i = 0; i < 8; i++) begin
            push_req(vecs[i].id, vecs[i].addr);
            m_rvalid_i = 1'b1;
            m_rdata_i  = mk_rdata(vecs[i].mv, vecs[i].md, vecs[i].mtag, vecs[i].line);
            #1;
            chk("vec m_rready", DATA_W'(m_rready_o), DATA_W'(1'b1));
            tick();
            m_rvalid_i = 1'b0;
            chk("vec hit_valid", DATA_W'(hit_valid_o), DATA_W'(vecs[i].exp_hit));
            chk("vec miss_valid", DATA_W'(miss_valid_o), DATA_W'(!vecs[i].exp_hit));
            if (vecs[i].exp_hit) begin
                chk("vec hit_id", DATA_W'(hit_id_o), DATA_W'(vecs[i].id));
                chk("vec hit_data", hit_data_o, vecs[i].line);
                eh++;
            end else begin
                chk("vec miss_id", DATA_W'(miss_id_o), DATA_W'(vecs[i].id));
                chk("vec miss_addr", DATA_W'(miss_addr_o), DATA_W'(vecs[i].addr));
                chk("vec miss_vtag", DATA_W'(miss_vtag_o), DATA_W'(vecs[i].mtag));
                chk("vec miss_vdirty", DATA_W'(miss_vdirty_o), DATA_W'(vecs[i].exp_vdirty));
                chk("vec miss_vdata", miss_vdata_o, vecs[i].line);
                em++;
            end
            tick();
            chk("vec drained", DATA_W'(hit_valid_o | miss_valid_o), DATA_W'(1'b0));
            check_counts("vec");
        end

        // Backpressure: first hit held while a second response waits.
        la = rand_line();
        lb = rand_line();
        hit_ready_i = 1'b0;
        push_req(16'h0010, 64'h2222_0000_0000_0010);
        push_req(16'h0011, 64'h3333_0000_0000_0011);
        m_rvalid_i = 1'b1;
        m_rdata_i  = mk_rdata(1'b1, 1'b0, 16'h2222, la);
        tick();
        m_rdata_i  = mk_rdata(1'b1, 1'b1, 16'h3333, lb);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp m_rready", DATA_W'(m_rready_o), DATA_W'(1'b0));
            chk("bp hit_valid", DATA_W'(hit_valid_o), DATA_W'(1'b1));
            chk("bp hit_id", DATA_W'(hit_id_o), DATA_W'(16'h0010));
            chk("bp hit_data", hit_data_o, la);
            tick();
        end
        hit_ready_i = 1'b1;
        #1;
        chk("bp release m_rready", DATA_W'(m_rready_o), DATA_W'(1'b1));
        tick();
        m_rvalid_i = 1'b0;
        eh++;
        chk("bp 2nd hit_valid", DATA_W'(hit_valid_o), DATA_W'(1'b1));
        chk("bp 2nd hit_id", DATA_W'(hit_id_o), DATA_W'(16'h0011));
        chk("bp 2nd hit_data", hit_data_o, lb);
        check_counts("bp mid");
        tick();
        eh++;
        chk("bp drained", DATA_W'(hit_valid_o), DATA_W'(1'b0));
        check_counts("bp end");

        // FIFO full, then push and accept together, then drain back-to-back.
        for (int k = 0; k < 4; k++) begin
            push_req(16'h0020 + 16'(k), {16'h4000 + 16'(k), 48'(k)});
        end
        #1;
        chk("full req_ready", DATA_W'(req_ready_o), DATA_W'(1'b0));
        req_valid_i = 1'b1;
        req_id_i    = 16'h0024;
        req_addr_i  = {16'h4004, 48'd4};
        m_rvalid_i  = 1'b1;
        m_rdata_i   = mk_rdata(1'b0, 1'b1, 16'h4000, 512'h0);
        tick();
        req_valid_i = 1'b0;
        chk("full after push+pop req_ready", DATA_W'(req_ready_o), DATA_W'(1'b0));
        chk("full miss_id 0", DATA_W'(miss_id_o), DATA_W'(16'h0020));
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("full order miss_valid", DATA_W'(miss_valid_o), DATA_W'(1'b1));
            chk("full order miss_id", DATA_W'(miss_id_o), DATA_W'(16'h0020 + 16'(k)));
            chk("full order miss_addr", DATA_W'(miss_addr_o), DATA_W'({16'h4000 + 16'(k), 48'(k)}));
            chk("full order vdirty", DATA_W'(miss_vdirty_o), DATA_W'(1'b0));
        end
        m_rvalid_i = 1'b0;
        #1;
        chk("full emptied req_ready", DATA_W'(req_ready_o), DATA_W'(1'b1));
        chk("full emptied m_rready", DATA_W'(m_rready_o), DATA_W'(1'b0));
        tick();
        em += 5;
        check_counts("full");

        // Reset with requests queued and a result held.
        hit_ready_i = 1'b0;
        push_req(16'h0030, 64'h5555_0000_0000_0000);
        push_req(16'h0031, 64'h5555_0000_0000_0001);
        push_req(16'h0032, 64'h5555_0000_0000_0002);
        m_rvalid_i = 1'b1;
        m_rdata_i  = mk_rdata(1'b1, 1'b0, 16'h5555, 512'h1);
        tick();
        m_rvalid_i = 1'b0;
        chk("pre-rst hit_valid", DATA_W'(hit_valid_o), DATA_W'(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        eh = 0;
        em = 0;
        chk("rst mid hit_valid", DATA_W'(hit_valid_o), DATA_W'(1'b0));
        chk("rst mid miss_valid", DATA_W'(miss_valid_o), DATA_W'(1'b0));
        chk("rst mid req_ready", DATA_W'(req_ready_o), DATA_W'(1'b1));
        chk("rst mid m_rready", DATA_W'(m_rready_o), DATA_W'(1'b0));
        check_counts("rst mid");
        hit_ready_i = 1'b1;

        // Randomized traffic against the queue model.
        mo_v = 1'b0;
        mo_hit = 1'b0;
        mo_req = '0;
        mo_tag = '0;
        mo_vd = 1'b0;
        mo_line = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_valid_i  = ($urandom % 2) == 0;
            req_id_i     = ID_W'($urandom);
            req_addr_i   = {tag_pool[$urandom % 4], 48'({$urandom, $urandom})};
            m_rvalid_i   = ($urandom % 3) != 0;
            r_v          = ($urandom % 4) != 0;
            r_d          = ($urandom % 2) == 0;
            if (mq.size() > 0 && ($urandom % 2) == 0) begin
                r_tag = addr_tag(mq[0].addr);
            end else begin
                r_tag = tag_pool[$urandom % 4];
            end
            r_line       = rand_line();
            m_rdata_i    = mk_rdata(r_v, r_d, r_tag, r_line);
            m_rid_i      = 1'($urandom);
            hit_ready_i  = ($urandom % 4) != 0;
            miss_ready_i = ($urandom % 4) != 0;
            #1;

            fire       = mo_v && (mo_hit ? hit_ready_i : miss_ready_i);
            exp_rready = (mq.size() > 0) && (!mo_v || fire);
            chk("rnd m_rready", DATA_W'(m_rready_o), DATA_W'(exp_rready));
            chk("rnd req_ready", DATA_W'(req_ready_o), DATA_W'(mq.size() < REQ_DEPTH));
            chk("rnd hit_valid", DATA_W'(hit_valid_o), DATA_W'(mo_v && mo_hit));
            chk("rnd miss_valid", DATA_W'(miss_valid_o), DATA_W'(mo_v && !mo_hit));
            if (mo_v && mo_hit) begin
                chk("rnd hit_id", DATA_W'(hit_id_o), DATA_W'(mo_req.id));
                chk("rnd hit_data", hit_data_o, mo_line);
            end
            if (mo_v && !mo_hit) begin
                chk("rnd miss_id", DATA_W'(miss_id_o), DATA_W'(mo_req.id));
                chk("rnd miss_addr", DATA_W'(miss_addr_o), DATA_W'(mo_req.addr));
                chk("rnd miss_vtag", DATA_W'(miss_vtag_o), DATA_W'(mo_tag));
                chk("rnd miss_vdirty", DATA_W'(miss_vdirty_o), DATA_W'(mo_vd));
                chk("rnd miss_vdata", miss_vdata_o, mo_line);
            end
            check_counts("rnd");

            accept = m_rvalid_i && exp_rready;
            sz     = mq.size();
            if (fire) begin
                if (mo_hit) eh++;
                else        em++;
                mo_v = 1'b0;
            end
            if (accept) begin
                head    = mq.pop_front();
                mo_v    = 1'b1;
                mo_hit  = r_v && (r_tag == head.addr[63:48]);
                mo_req  = head;
                mo_tag  = r_tag;
                mo_vd   = r_v && r_d;
                mo_line = r_line;
            end
            if (req_valid_i && (sz < REQ_DEPTH || accept)) begin
                mq.push_back('{id: req_id_i, addr: req_addr_i});
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
